// File: rtl/gray_code_unit_if.sv
// rtl/gray_code_unit_if.sv - converter operands/results and pointer bundle for gray_code_unit
interface gray_code_unit_if #(
    parameter int BINARY_WIDTH = 5
);
    logic [BINARY_WIDTH-1:0] conv_binary_in;
    logic [BINARY_WIDTH-1:0] conv_gray_out;
    logic [BINARY_WIDTH-1:0] conv_gray_in;
    logic [BINARY_WIDTH-1:0] conv_binary_out;
    logic                    inc_en;
    logic [BINARY_WIDTH-1:0] ptr_gray;
    logic [BINARY_WIDTH-1:0] ptr_binary;
    logic [BINARY_WIDTH-1:0] ptr_gray_next;

    modport master (
        output conv_binary_in, conv_gray_in, inc_en,
        input  conv_gray_out, conv_binary_out, ptr_gray, ptr_binary, ptr_gray_next
    );

    modport slave (
        input  conv_binary_in, conv_gray_in, inc_en,
        output conv_gray_out, conv_binary_out, ptr_gray, ptr_binary, ptr_gray_next
    );
endinterface

// File: rtl/gray_code_unit.sv
// rtl/gray_code_unit.sv - binary/Gray converters and a Gray-coded CDC pointer counter
module gray_code_unit #(
    parameter int BINARY_WIDTH = 5
) (
    input  logic              clk,
    input  logic              reset,
    gray_code_unit_if.slave   bus
);
    localparam int W = BINARY_WIDTH;

    logic [W-1:0] ptr_gray_q;
    logic [W-1:0] ptr_binary_w;
    logic [W-1:0] ptr_gray_next_w;

    function automatic logic [W-1:0] bin_to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it, built MSB-down.
    function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign bus.conv_gray_out   = bin_to_gray(bus.conv_binary_in);
    assign bus.conv_binary_out = gray_to_bin(bus.conv_gray_in);

    // Only the Gray value is registered so the pointer crossing domains is glitch-safe.
    assign ptr_binary_w    = gray_to_bin(ptr_gray_q);
    assign ptr_gray_next_w = bin_to_gray(ptr_binary_w + W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_gray_q <= '0;
        end else if (bus.inc_en) begin
            ptr_gray_q <= ptr_gray_next_w;
        end
    end

    assign bus.ptr_gray      = ptr_gray_q;
    assign bus.ptr_binary    = ptr_binary_w;
    assign bus.ptr_gray_next = ptr_gray_next_w;
endmodule

// File: tb/tb_gray_code_unit.sv
// tb/tb_gray_code_unit.sv - scoreboard bench for gray_code_unit at widths 5, 1 and 8
module tb_gray_code_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gray_code_unit_if #(.BINARY_WIDTH(5)) if5 ();
    gray_code_unit_if #(.BINARY_WIDTH(1)) if1 ();
    gray_code_unit_if #(.BINARY_WIDTH(8)) if8 ();

    gray_code_unit #(.BINARY_WIDTH(5)) dut5 (.clk(clk), .reset(reset), .bus(if5.slave));
    gray_code_unit #(.BINARY_WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    gray_code_unit #(.BINARY_WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

    // o[unit][sel]: unit 0=W5, 1=W1, 2=W8; sel 0..4 = gray_out, binary_out, ptr_gray, ptr_binary, ptr_gray_next
    logic [7:0] o [3][5];
    assign o[0][0] = 8'(if5.conv_gray_out);
    assign o[0][1] = 8'(if5.conv_binary_out);
    assign o[0][2] = 8'(if5.ptr_gray);
    assign o[0][3] = 8'(if5.ptr_binary);
    assign o[0][4] = 8'(if5.ptr_gray_next);
    assign o[1][0] = 8'(if1.conv_gray_out);
    assign o[1][1] = 8'(if1.conv_binary_out);
    assign o[1][2] = 8'(if1.ptr_gray);
    assign o[1][3] = 8'(if1.ptr_binary);
    assign o[1][4] = 8'(if1.ptr_gray_next);
    assign o[2][0] = 8'(if8.conv_gray_out);
    assign o[2][1] = 8'(if8.conv_binary_out);
    assign o[2][2] = 8'(if8.ptr_gray);
    assign o[2][3] = 8'(if8.ptr_binary);
    assign o[2][4] = 8'(if8.ptr_gray_next);

    typedef struct {
        int         unit;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] last_gray [3];
    string      sel_name [6];

    initial begin
        sel_name[0] = "conv_gray_out";
        sel_name[1] = "conv_binary_out";
        sel_name[2] = "ptr_gray";
        sel_name[3] = "ptr_binary";
        sel_name[4] = "ptr_gray_next";
        sel_name[5] = "ptr_gray_step_bits";
        for (int i = 0; i < 3; i++) last_gray[i] = 8'd0;
    end

    // sel 5 checks the Hamming distance from the previously checked ptr_gray.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e = sb.pop_front();
            if (e.sel == 5) act = 8'($countones(o[e.unit][2] ^ last_gray[e.unit]));
            else            act = o[e.unit][e.sel];
            if (e.sel == 2) last_gray[e.unit] = act;
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s unit%0d @%0t: got %0h expected %0h",
                         sel_name[e.sel], e.unit, $time, act, e.exp);
            end
        end
    end

    function automatic logic [7:0] gray8(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic expect_val(input int unit, input int sel, input logic [7:0] exp);
        exp_t e;
        e.unit = unit;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ptr(input int u, input int w, input int b, input bit step);
        logic [7:0] m;
        logic [7:0] bb;
        m  = 8'((1 << w) - 1);
        bb = 8'(b) & m;
        if (step) expect_val(u, 5, 8'd1);
        expect_val(u, 2, gray8(bb));
        expect_val(u, 3, bb);
        expect_val(u, 4, gray8((bb + 8'd1) & m));
    endtask

    task automatic do_reset(input int u, input int w);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_ptr(u, w, 0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        if5.conv_binary_in = '0; if5.conv_gray_in = '0; if5.inc_en = 1'b0;
        if1.conv_binary_in = '0; if1.conv_gray_in = '0; if1.inc_en = 1'b0;
        if8.conv_binary_in = '0; if8.conv_gray_in = '0; if8.inc_en = 1'b0;
        tick();
        reset = 1'b0;
        expect_val(0, 2, 8'h00); expect_val(0, 3, 8'h00); expect_val(0, 4, 8'h01);
        check_ptr(1, 1, 0, 1'b0);
        check_ptr(2, 8, 0, 1'b0);
        tick();

        // Directed converter vectors
        if5.conv_binary_in = 5'b01011; if5.conv_gray_in = 5'b01110; #1;
        expect_val(0, 0, 8'b01110); expect_val(0, 1, 8'b01011);
        tick();
        if5.conv_binary_in = 5'b11111; if5.conv_gray_in = 5'b10000; #1;
        expect_val(0, 0, 8'b10000); expect_val(0, 1, 8'b11111);
        tick();

        // Exhaustive round trip at all widths
        for (int b = 0; b < 32; b++) begin
            if5.conv_binary_in = 5'(b); if5.conv_gray_in = 5'(gray8(8'(b))); #1;
            expect_val(0, 0, gray8(8'(b))); expect_val(0, 1, 8'(b));
            tick();
        end
        for (int b = 0; b < 2; b++) begin
            if1.conv_binary_in = 1'(b); if1.conv_gray_in = 1'(b); #1;
            expect_val(1, 0, 8'(b)); expect_val(1, 1, 8'(b));
            tick();
        end
        for (int b = 0; b < 256; b++) begin
            if8.conv_binary_in = 8'(b); if8.conv_gray_in = gray8(8'(b)); #1;
            expect_val(2, 0, gray8(8'(b))); expect_val(2, 1, 8'(b));
            tick();
        end

        // Full W=5 count including wrap
        do_reset(0, 5);
        if5.inc_en = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            check_ptr(0, 5, i, 1'b1);
        end
        expect_val(0, 2, 8'b10000); expect_val(0, 4, 8'h00);
        tick();
        check_ptr(0, 5, 0, 1'b1);
        expect_val(0, 2, 8'h00);
        if5.inc_en = 1'b0;

        // inc_en pattern 1,0,0,1
        do_reset(0, 5);
        if5.inc_en = 1'b1; tick(); check_ptr(0, 5, 1, 1'b1);
        if5.inc_en = 1'b0; tick(); check_ptr(0, 5, 1, 1'b0);
        tick();                    check_ptr(0, 5, 1, 1'b0);
        if5.inc_en = 1'b1; tick(); check_ptr(0, 5, 2, 1'b1);

        // Reset wins over inc_en mid-count
        do_reset(0, 5);
        for (int i = 1; i <= 13; i++) begin
            tick();
            check_ptr(0, 5, i, 1'b1);
        end
        reset = 1'b1; tick(); check_ptr(0, 5, 0, 1'b0);
        reset = 1'b0;
        tick(); check_ptr(0, 5, 1, 1'b1);
        tick(); check_ptr(0, 5, 2, 1'b1);
        if5.inc_en = 1'b0;

        // W=1 toggles
        do_reset(1, 1);
        if1.inc_en = 1'b1;
        tick(); check_ptr(1, 1, 1, 1'b1);
        tick(); check_ptr(1, 1, 0, 1'b1);
        if1.inc_en = 1'b0;

        // W=8 full count and wrap
        do_reset(2, 8);
        if8.inc_en = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            check_ptr(2, 8, i, 1'b1);
        end
        expect_val(2, 2, 8'h80);
        tick();
        check_ptr(2, 8, 0, 1'b1);
        if8.inc_en = 1'b0;

        tick();
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_code_unit.md
Name:
gray_code_unit

Overview:
- Gray-code support block for pointer handling in clock-domain-crossing FIFOs.
- Provides two combinational converters, binary-to-Gray and Gray-to-binary, for arbitrary width.
- Also provides a registered Gray-coded pointer counter with binary and next-value views.
- Sits beside the FIFO read/write pointer logic; the Gray pointer output is the value that is safe to synchronise into another clock domain.

Parameters:
- BINARY_WIDTH, 5, width in bits of every binary and Gray value. Must be >= 1. Counter wraps modulo 2^BINARY_WIDTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- conv_binary_in  in  BINARY_WIDTH  binary operand for the binary-to-Gray converter
- conv_gray_out  out  BINARY_WIDTH  Gray code of conv_binary_in (combinational)
- conv_gray_in  in  BINARY_WIDTH  Gray operand for the Gray-to-binary converter
- conv_binary_out  out  BINARY_WIDTH  binary value of conv_gray_in (combinational)
- inc_en  in  1  advance the pointer by one on the next rising clk edge
- ptr_gray  out  BINARY_WIDTH  registered pointer, Gray coded
- ptr_binary  out  BINARY_WIDTH  binary view of ptr_gray (combinational from the register)
- ptr_gray_next  out  BINARY_WIDTH  Gray code of ptr_binary+1 mod 2^W (combinational)

Behaviour:
- Binary-to-Gray: gray = binary XOR (binary >> 1), i.e. gray[W-1] = b[W-1], gray[i] = b[i+1] ^ b[i].
- Gray-to-binary: b[W-1] = g[W-1], b[i] = b[i+1] ^ g[i] (XOR prefix from the MSB). Equivalently, b[i] is the XOR of g[W-1:i].
- Both converters are purely combinational with zero latency. They are independent of clk, reset and the counter.
- The two converters are exact inverses for all 2^W values.
- The only state is ptr_gray (W flops). All other outputs are combinational.
- Reset: on a rising clk edge with reset=1, ptr_gray <= 0, so ptr_binary=0 and ptr_gray_next = Gray(1) = 1. reset has priority over inc_en.
- Increment: on a rising clk edge with reset=0 and inc_en=1, ptr_gray <= ptr_gray_next.
- Hold: on a rising clk edge with reset=0 and inc_en=0, ptr_gray holds its value.
- Width rule: ptr_binary+1 is truncated to W bits.
- Wrap-around: binary 2^W-1 (Gray 1 followed by W-1 zeros) is followed by 0 (Gray all zeros).
- Successive ptr_gray values always differ in exactly one bit, including across the wrap.
- Before the first reset, ptr_gray is undefined. Users must assert reset before relying on it.
- W=1: Gray equals binary, and the pointer toggles 0,1,0,...

Test Plan:
- Converter, W=5: conv_binary_in=5'b01011 -> conv_gray_out=5'b01110; conv_gray_in=5'b01110 -> conv_binary_out=5'b01011; binary 5'b11111 <-> Gray 5'b10000.
- Exhaustive round-trip, W=5: for all 32 binary values, drive Gray(b) back into conv_gray_in -> conv_binary_out == b. All 32 Gray outputs are distinct.
- Reset, then 31 cycles with inc_en=1 -> ptr_binary=31, ptr_gray=5'b10000, ptr_gray_next=5'b00000. One more increment -> ptr_gray=0, ptr_binary=0. Check single-bit change on every step.
- inc_en toggling 1,0,0,1 from reset -> ptr_binary sequence 0,1,1,1,2 (sampled after each edge); no change while inc_en=0.
- Reset mid-count: at ptr_binary=13, assert reset with inc_en=1 for one cycle -> ptr_gray=0 after that edge. Deassert reset -> counting resumes 1,2,...
- Parameter sweep W=1 and W=8: W=1 pointer sequence 0,1,0; W=8 wrap from 255 (Gray 8'h80) to 0; round-trip check over all values.
